// File: rtl/vhf_serial_ctrl_if.sv
// Bus bundle for the VHF front-end serial control stage: tuning inputs in,
// DATA/CLK/EN shift-register lines and status out.
interface vhf_serial_ctrl_if;
  logic [31:0] freq;
  logic        preamp;
  logic        ser_data;
  logic        ser_clk;
  logic        ser_en;
  logic        busy;
  logic [2:0]  band_code;

  modport master (
    output freq, preamp,
    input  ser_data, ser_clk, ser_en, busy, band_code
  );

  modport slave (
    input  freq, preamp,
    output ser_data, ser_clk, ser_en, busy, band_code
  );
endinterface

// File: rtl/vhf_serial_ctrl.sv
// VHF front-end serial controller: decodes the tuned frequency into a filter
// band, waits for the control word to settle and shifts it out MSB-first.
module vhf_serial_ctrl #(
  parameter int CLK_DIV = 8,
  parameter int SETTLE  = 1024
) (
  input logic               clock,
  input logic               reset,
  vhf_serial_ctrl_if.slave  bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  function automatic logic [2:0] band_of(input logic [15:0] f);
    logic [2:0] code;
    if      (f <= 16'd458)  code = 3'd0;
    else if (f <= 16'd824)  code = 3'd1;
    else if (f <= 16'd1342) code = 3'd2;
    else if (f <= 16'd1647) code = 3'd3;
    else if (f <= 16'd2258) code = 3'd4;
    else if (f <= 16'd2655) code = 3'd5;
    else                    code = 3'd6;
    return code;
  endfunction

  // Filter select is one-hot at bit 7+code, except the top band which uses bit 14.
  function automatic logic [15:0] word_of(input logic [2:0] code, input logic pa);
    logic [15:0] w;
    w = '0;
    case (code)
      3'd1:    w[8]  = 1'b1;
      3'd2:    w[9]  = 1'b1;
      3'd3:    w[10] = 1'b1;
      3'd4:    w[11] = 1'b1;
      3'd5:    w[12] = 1'b1;
      3'd6:    w[14] = 1'b1;
      default: w[15:8] = '0;
    endcase
    w[7]   = (code != 3'd0);
    w[6:4] = code;
    w[3]   = pa && (code != 3'd0);
    return w;
  endfunction

  logic [2:0]       band_code_p0;
  logic [15:0]      word;
  logic [15:0]      word_prev;
  logic [CNT_W-1:0] settle_cnt;
  logic [15:0]      last_sent;
  logic [15:0]      shift;
  logic             pending;
  logic             req;

  logic [2:0]       state;
  logic [DIV_W-1:0] div;
  logic [3:0]       idx;
  logic             ser_data_r;
  logic             ser_clk_r;
  logic             ser_en_r;
  logic             busy_r;

  logic unused_freq_lsb;
  assign unused_freq_lsb = ^bus.freq[15:0];

  assign word = word_of(band_code_p0, bus.preamp);
  assign req  = (settle_cnt == SETTLE_C) && (word == word_prev) &&
                ((word != last_sent) || pending);

  // Band decode and settle tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      band_code_p0 <= '0;
      word_prev    <= '0;
      settle_cnt   <= '0;
    end else begin
      band_code_p0 <= band_of(bus.freq[31:16]);
      word_prev    <= word;
      if (word != word_prev)
        settle_cnt <= '0;
      else if (settle_cnt != SETTLE_C)
        settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Word in flight is frozen here so input changes cannot disturb a transfer.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && req) begin
      shift     <= word;
      last_sent <= word;
    end
  end

  // Serial transfer sequencer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      div        <= '0;
      idx        <= '0;
      pending    <= 1'b1;
      ser_data_r <= 1'b0;
      ser_clk_r  <= 1'b0;
      ser_en_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ser_clk_r <= 1'b0;
          ser_en_r  <= 1'b0;
          if (req) begin
            state   <= S_LOAD;
            busy_r  <= 1'b1;
            pending <= 1'b0;
            idx     <= 4'd15;
          end
        end
        S_LOAD: begin
          state      <= S_LO;
          div        <= '0;
          ser_data_r <= shift[15];
        end
        S_LO: begin
          if (div == DIV_LAST) begin
            div       <= '0;
            state     <= S_HI;
            ser_clk_r <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        S_HI: begin
          if (div == DIV_LAST) begin
            div       <= '0;
            ser_clk_r <= 1'b0;
            if (idx == 4'd0) begin
              state      <= S_LATCH;
              ser_data_r <= 1'b0;
              ser_en_r   <= 1'b1;
            end else begin
              idx        <= idx - 4'd1;
              state      <= S_LO;
              ser_data_r <= shift[idx - 4'd1];
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        S_LATCH: begin
          if (div == DIV_LAST) begin
            div      <= '0;
            ser_en_r <= 1'b0;
            busy_r   <= 1'b0;
            state    <= S_IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.band_code = band_code_p0;
  assign bus.ser_data  = ser_data_r;
  assign bus.ser_clk   = ser_clk_r;
  assign bus.ser_en    = ser_en_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_vhf_serial_ctrl.sv
// Bench for vhf_serial_ctrl: a bus monitor reassembles each transfer and a
// frequency-to-word model supplies the expected band codes and words.
module tb_vhf_serial_ctrl;

  localparam int CD = 4;
  localparam int ST = 16;
  localparam int XFER_LEN = 1 + 32 * CD + CD;

  logic clock = 1'b0;
  logic reset;

  vhf_serial_ctrl_if vif ();

  vhf_serial_ctrl #(.CLK_DIV(CD), .SETTLE(ST)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          en_cyc;
    int          busy_cyc;
    int          gap;
    int          bad_en;
  } xfer_t;

  xfer_t       xq[$];
  int          tot_rise;
  int          tot_en;
  int          n_chk;
  int          n_err;
  logic [15:0] last_sent;

  function automatic int ref_code(input logic [31:0] fq);
    int f;
    f = int'(fq >> 16);
    if (f <= 458)  return 0;
    if (f <= 824)  return 1;
    if (f <= 1342) return 2;
    if (f <= 1647) return 3;
    if (f <= 2258) return 4;
    if (f <= 2655) return 5;
    return 6;
  endfunction

  function automatic logic [15:0] ref_word(input logic [31:0] fq, input logic pa);
    int c;
    int w;
    c = ref_code(fq);
    w = 0;
    if (c == 6) w = 'h4000;
    else if (c != 0) w = 1 << (7 + c);
    if (c != 0) w = w + 'h80 + (c << 4) + (pa ? 8 : 0);
    return 16'(w);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_in(input logic [31:0] f, input logic p);
    vif.freq   = f;
    vif.preamp = p;
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int i;
    i = 0;
    while (xq.size() < target && i < budget) begin
      step(1);
      i++;
    end
    if (xq.size() < target) chk("xfer_timeout", 32'(xq.size()), 32'(target));
  endtask

  task automatic wait_busy(input int budget);
    int i;
    i = 0;
    while (!vif.busy && i < budget) begin
      step(1);
      i++;
    end
    if (!vif.busy) chk("busy_timeout", 32'(vif.busy), 32'd1);
  endtask

  task automatic check_next(input string tag, input logic [15:0] expw);
    xfer_t x;
    if (xq.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      x = xq.pop_front();
      chk({tag, "_word"},  32'(x.word), 32'(expw));
      chk({tag, "_bit15"}, 32'(x.word[15]), 32'd0);
      chk({tag, "_rises"}, 32'(x.nbits), 32'd16);
      chk({tag, "_en"},    32'(x.en_cyc), 32'(CD));
      chk({tag, "_busy"},  32'(x.busy_cyc), 32'(XFER_LEN));
      chk({tag, "_latch_lines"}, 32'(x.bad_en), 32'd0);
      last_sent = expw;
    end
  endtask

  // Bus monitor, sampled on the falling edge
  initial begin
    xfer_t cur;
    logic  in_x;
    logic  pbusy;
    logic  pclk;
    int    gap;
    in_x = 1'b0; pbusy = 1'b0; pclk = 1'b0; gap = 0;
    cur.word = '0; cur.nbits = 0; cur.en_cyc = 0;
    cur.busy_cyc = 0; cur.gap = 0; cur.bad_en = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        in_x = 1'b0; pbusy = 1'b0; pclk = 1'b0; gap = 0;
      end else begin
        if (vif.ser_clk && !pclk) tot_rise++;
        if (vif.ser_en) tot_en++;
        if (vif.busy && !pbusy) begin
          cur.word = '0; cur.nbits = 0; cur.en_cyc = 0;
          cur.busy_cyc = 0; cur.bad_en = 0;
          cur.gap = gap;
          gap = 0;
          in_x = 1'b1;
        end
        if (in_x && vif.busy) begin
          cur.busy_cyc++;
          if (vif.ser_clk && !pclk) begin
            cur.word = {cur.word[14:0], vif.ser_data};
            cur.nbits++;
          end
          if (vif.ser_en) begin
            cur.en_cyc++;
            if (vif.ser_clk || vif.ser_data) cur.bad_en++;
          end
        end
        if (!vif.busy) begin
          gap++;
          if (in_x) begin
            xq.push_back(cur);
            in_x = 1'b0;
          end
        end
        pbusy = vif.busy;
        pclk  = vif.ser_clk;
      end
    end
  end

  initial begin
    logic [31:0] bnd [4];
    int          bexp [4];
    logic [31:0] fr;
    logic        pa;
    int          r0;
    int          e0;
    xfer_t       x;

    bnd  = '{32'h01CA_FFFF, 32'h01CB_0000, 32'h0A50_0000, 32'h0A60_0000};
    bexp = '{0, 1, 5, 6};
    n_chk = 0; n_err = 0; tot_rise = 0; tot_en = 0; last_sent = '0;

    reset = 1'b1;
    set_in(32'd50_000_000, 1'b0);
    step(3);
    chk("rst_ser_data", 32'(vif.ser_data), 32'd0);
    chk("rst_ser_clk",  32'(vif.ser_clk), 32'd0);
    chk("rst_ser_en",   32'(vif.ser_en), 32'd0);
    chk("rst_busy",     32'(vif.busy), 32'd0);
    chk("rst_band",     32'(vif.band_code), 32'd0);
    reset = 1'b0;

    wait_xfers(1, 400);
    check_next("first", ref_word(32'd50_000_000, 1'b0));

    set_in(32'd100_000_000, 1'b1);
    @(negedge clock);
    chk("band_before_edge", 32'(vif.band_code), 32'(ref_code(32'd50_000_000)));
    step(1);
    chk("band_after_edge", 32'(vif.band_code), 32'(ref_code(32'd100_000_000)));
    wait_xfers(1, 400);
    check_next("preamp", ref_word(32'd100_000_000, 1'b1));

    r0 = tot_rise; e0 = tot_en;
    step(10000);
    chk("quiet_rises", 32'(tot_rise), 32'(r0));
    chk("quiet_en",    32'(tot_en), 32'(e0));
    chk("quiet_xfers", 32'(xq.size()), 32'd0);

    r0 = tot_rise;
    for (int i = 0; i < 20; i++) begin
      set_in((i % 2 == 0) ? 32'd50_000_000 : 32'd60_000_000, 1'b0);
      step(8);
    end
    chk("toggle_rises", 32'(tot_rise), 32'(r0));
    chk("toggle_xfers", 32'(xq.size()), 32'd0);
    set_in(32'd60_000_000, 1'b0);
    wait_xfers(1, 400);
    check_next("settled60", ref_word(32'd60_000_000, 1'b0));

    // Change the tuning while bit 10 is in its low phase
    set_in(32'd50_000_000, 1'b0);
    wait_busy(400);
    step(2 + 10 * CD);
    chk("bit10_lo_phase", 32'(vif.ser_clk), 32'd0);
    set_in(32'd150_000_000, 1'b0);
    wait_xfers(2, 800);
    check_next("inflight", ref_word(32'd50_000_000, 1'b0));
    if (xq.size() > 0) chk("back_to_back_gap", 32'(xq[0].gap), 32'd1);
    check_next("followup", ref_word(32'd150_000_000, 1'b0));

    // Reset while bit 5 is in its high phase
    do begin
      fr = {16'(459 + $urandom_range(0, 2100)), 16'($urandom)};
      pa = 1'($urandom);
    end while (ref_word(fr, pa) == last_sent);
    set_in(fr, pa);
    wait_busy(400);
    step(2 + 21 * CD);
    chk("bit5_hi_phase", 32'(vif.ser_clk), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_ser_clk",  32'(vif.ser_clk), 32'd0);
    chk("midrst_ser_data", 32'(vif.ser_data), 32'd0);
    chk("midrst_ser_en",   32'(vif.ser_en), 32'd0);
    chk("midrst_busy",     32'(vif.busy), 32'd0);
    step(3);
    reset = 1'b0;
    wait_xfers(1, 400);
    check_next("after_reset", ref_word(fr, pa));

    for (int i = 0; i < 4; i++) begin
      set_in(bnd[i], 1'b1);
      step(1);
      chk($sformatf("boundary%0d", i), 32'(vif.band_code), 32'(bexp[i]));
    end
    for (int i = 0; i < 8; i++) begin
      fr = $urandom;
      set_in(fr, 1'($urandom));
      step(1);
      chk($sformatf("rand_band%0d", i), 32'(vif.band_code), 32'(ref_code(fr)));
    end
    set_in(32'h0A60_0000, 1'b1);
    wait_xfers(1, 400);
    check_next("top_band", ref_word(32'h0A60_0000, 1'b1));

    for (int i = 0; i < 4; i++) begin
      fr = $urandom;
      pa = 1'($urandom);
      set_in(fr, pa);
      step(ST + 40);
      if (ref_word(fr, pa) != last_sent) begin
        wait_xfers(1, 400);
        check_next($sformatf("rand_xfer%0d", i), ref_word(fr, pa));
      end else begin
        step(XFER_LEN + 20);
        chk($sformatf("rand_none%0d", i), 32'(xq.size()), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
